debounce_toggle_req: RTL and testbench

- Conditions a raw, asynchronous, bouncy push-button input into a clean single-cycle toggle request.
- Sits directly upstream of the toggle flip-flop stage. t_pulse drives that stage's t input, in the same clk/reset domain.
- Also exports the debounced button level for status/LED use.

---
 rtl/debounce_toggle_req_pkg.sv | 21 ++
 rtl/debounce_toggle_req_bit_sync.sv | 29 ++
 rtl/debounce_toggle_req.sv | 115 +++++++++++
 tb/tb_debounce_toggle_req.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_toggle_req_pkg.sv
// Shared types and helpers for the button debounce / toggle-request slice.
// State encoding, accepted-edge selection codes and counter sizing.
package debounce_toggle_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int EDGE_PRESS   = 0;
    localparam int EDGE_RELEASE = 1;
    localparam int EDGE_BOTH    = 2;

    // Enough bits to hold the qualification count without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_toggle_req_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; latency STAGES cycles.
// No backpressure; the chain is a pure delay line with asynchronous reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_toggle_req.sv
// Debounces a raw button into a registered level and a one-cycle toggle request.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles; no backpressure, pulses are fire-and-forget.
module debounce_toggle_req
    import debounce_toggle_req_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_SEL        = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             t_pulse_d, t_pulse_q;
    logic             btn_level_d, btn_level_q;
    logic             press_acc, release_acc;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_bit_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            btn_level_q <= btn_level_d;
        end
    end

    // Any opposite sample inside a WAIT state falls back to the stable state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sync_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!sync_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        press_acc   = (state_q == ST_PRESS_WAIT) && sync_q && (cnt_q == CNT_MAX);
        release_acc = (state_q == ST_RELEASE_WAIT) && !sync_q && (cnt_q == CNT_MAX);

        btn_level_d = btn_level_q;
        if (press_acc) begin
            btn_level_d = 1'b1;
        end else if (release_acc) begin
            btn_level_d = 1'b0;
        end

        t_pulse_d = 1'b0;
        case (EDGE_SEL)
            EDGE_PRESS:   t_pulse_d = press_acc;
            EDGE_RELEASE: t_pulse_d = release_acc;
            EDGE_BOTH:    t_pulse_d = press_acc || release_acc;
            default:      t_pulse_d = 1'b0;
        endcase
    end

    assign t_pulse   = t_pulse_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_debounce_toggle_req.sv
// Directed bench: default press-edge, release-edge and both-edge (short debounce) instances.
// All instances share clk, reset and btn_in; each scenario checks the instance it targets.
module tb_debounce_toggle_req;

    logic clk;
    logic reset;
    logic btn_in;

    logic t_pulse_def, btn_level_def;
    logic t_pulse_rel, btn_level_rel;
    logic t_pulse_both, btn_level_both;
    logic tq;

    int checks;
    int failures;

    debounce_toggle_req dut_def (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse_def),
        .btn_level (btn_level_def)
    );

    debounce_toggle_req #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .EDGE_SEL        (1)
    ) dut_rel (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse_rel),
        .btn_level (btn_level_rel)
    );

    debounce_toggle_req #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_SEL        (2)
    ) dut_both (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse_both),
        .btn_level (btn_level_both)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream toggle stage fed by the default instance.
    always @(posedge clk or posedge reset) begin
        if (reset) tq <= 1'b0;
        else if (t_pulse_def) tq <= ~tq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        btn_in = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        btn_in = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        checks++;
        if (t_pulse_def !== 1'b0 || btn_level_def !== 1'b0 ||
            t_pulse_both !== 1'b0 || btn_level_both !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: t_pulse=%b level=%b both=%b/%b want 0",
                     t_pulse_def, btn_level_def, t_pulse_both, btn_level_both);
        end
        reset = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            checks++;
            if (t_pulse_def !== 1'b0 || btn_level_def !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet e=%0d: t_pulse=%b level=%b want 0 0",
                         e, t_pulse_def, btn_level_def);
            end
        end
    endtask

    task automatic test_press_release();
        apply_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (t_pulse_def !== (e == 18) || btn_level_def !== (e >= 18) ||
                t_pulse_rel !== 1'b0 || btn_level_rel !== (e >= 18)) begin
                failures++;
                $display("FAIL press e=%0d: def=%b/%b rel=%b/%b want %b/%b 0/%b",
                         e, t_pulse_def, btn_level_def, t_pulse_rel, btn_level_rel,
                         (e == 18), (e >= 18), (e >= 18));
            end
        end
        btn_in = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (t_pulse_def !== 1'b0 || btn_level_def !== (e < 18) ||
                t_pulse_rel !== (e == 18) || btn_level_rel !== (e < 18)) begin
                failures++;
                $display("FAIL release e=%0d: def=%b/%b rel=%b/%b want 0/%b %b/%b",
                         e, t_pulse_def, btn_level_def, t_pulse_rel, btn_level_rel,
                         (e < 18), (e == 18), (e < 18));
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            btn_in = (((c / 3) % 2) == 0);
            tick();
            checks++;
            if (t_pulse_def !== 1'b0 || btn_level_def !== 1'b0 ||
                t_pulse_both !== 1'b0 || btn_level_both !== 1'b0) begin
                failures++;
                $display("FAIL bounce c=%0d: def=%b/%b both=%b/%b want 0",
                         c, t_pulse_def, btn_level_def, t_pulse_both, btn_level_both);
            end
        end
        btn_in = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (t_pulse_def !== (e == 18) || btn_level_def !== (e >= 18)) begin
                failures++;
                $display("FAIL bounce_settle e=%0d: t_pulse=%b level=%b want %b %b",
                         e, t_pulse_def, btn_level_def, (e == 18), (e >= 18));
            end
        end
    endtask

    task automatic test_both_edges();
        int pulses;
        pulses = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            btn_in = 1'b1;
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (t_pulse_both) pulses++;
                checks++;
                if (t_pulse_both !== (e == 6) || btn_level_both !== (e >= 6)) begin
                    failures++;
                    $display("FAIL both_press p=%0d e=%0d: t_pulse=%b level=%b want %b %b",
                             p, e, t_pulse_both, btn_level_both, (e == 6), (e >= 6));
                end
            end
            btn_in = 1'b0;
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (t_pulse_both) pulses++;
                checks++;
                if (t_pulse_both !== (e == 6) || btn_level_both !== (e < 6)) begin
                    failures++;
                    $display("FAIL both_release p=%0d e=%0d: t_pulse=%b level=%b want %b %b",
                             p, e, t_pulse_both, btn_level_both, (e == 6), (e < 6));
                end
            end
        end
        checks++;
        if (pulses !== 6) begin
            failures++;
            $display("FAIL both_count: pulses=%0d want 6", pulses);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 40; e++) tick();
        checks++;
        if (btn_level_def !== 1'b1) begin
            failures++;
            $display("FAIL glitch_pre: level=%b want 1", btn_level_def);
        end
        btn_in = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c == 14) btn_in = 1'b1;
            tick();
            checks++;
            if (t_pulse_def !== 1'b0 || btn_level_def !== 1'b1 || t_pulse_rel !== 1'b0) begin
                failures++;
                $display("FAIL glitch c=%0d: def=%b/%b rel_pulse=%b want 0/1 0",
                         c, t_pulse_def, btn_level_def, t_pulse_rel);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        checks++;
        if (btn_level_both !== 1'b1 || btn_level_def !== 1'b0) begin
            failures++;
            $display("FAIL mid_pre: both_level=%b def_level=%b want 1 0",
                     btn_level_both, btn_level_def);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (t_pulse_def !== 1'b0 || btn_level_def !== 1'b0 ||
            btn_level_both !== 1'b0 || t_pulse_both !== 1'b0 || tq !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: def=%b/%b both=%b/%b tq=%b want 0",
                     t_pulse_def, btn_level_def, t_pulse_both, btn_level_both, tq);
        end
        tick();
        tick();
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (t_pulse_def !== (e == 18) || btn_level_def !== (e >= 18) ||
                tq !== (e >= 19)) begin
                failures++;
                $display("FAIL post_reset e=%0d: t_pulse=%b level=%b tq=%b want %b %b %b",
                         e, t_pulse_def, btn_level_def, tq, (e == 18), (e >= 18), (e >= 19));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        btn_in   = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_both_edges();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
